uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the UART receiver. Captures each
//  byte presented with a one-cycle done strobe and queues it in a synchronous FIFO.
//  Presents bytes to the consumer (command parser / loopback TX) on a valid/ready
//  interface. Reports fill level, almost-full, sticky overflow and a saturating count
//  of dropped bytes, so 921600-baud bursts survive consumer stalls.
// PARAMETERS
//  DEPTH        16  entries; power of two, >=2
//  AW           4   pointer width = log2(DEPTH)
//  AFULL_LEVEL  12  almost_full asserts when count >= AFULL_LEVEL
// PORTS
//  clk           in   1     system clock (100 MHz)
//  reset_n       in   1     asynchronous, active-low reset
//  rx_data       in   8     byte from receiver; sampled only when rx_done=1
//  rx_done       in   1     one-cycle strobe: rx_data valid this cycle (push request)
//  flush         in   1     synchronous clear of FIFO contents
//  out_data      out  8     head-of-queue byte (first-word-fall-through)
//  out_valid     out  1     FIFO non-empty
//  out_ready     in   1     consumer accepts out_data when out_valid && out_ready (pop)
//  count         out  AW+1  number of stored bytes, 0..DEPTH
//  almost_full   out  1     count >= AFULL_LEVEL
//  overflow      out  1     sticky: at least one byte dropped since last clear
//  overflow_clr  in   1     clears overflow and drop_cnt
//  drop_cnt      out  8     dropped-byte counter, saturates at 255
// BEHAVIOUR
//  - Reset (reset_n=0, async): rd_ptr=wr_ptr=0, count=0, out_valid=0, almost_full=0,
//    overflow=0, drop_cnt=0. out_data is don't-care while out_valid=0. Storage array
//    is not reset. Reset mid-burst discards all stored bytes; no partial state remains.
//  - push = rx_done; pop = out_valid && out_ready. All updates on posedge clk.
//  - Latency: a byte pushed into an empty FIFO gives out_valid=1 and out_data=byte on
//    the cycle after rx_done (one clock).
//  - out_data = mem[rd_ptr] combinationally; out_valid = (count != 0).
//  - Pointers are AW bits and wrap naturally DEPTH-1 -> 0; count is tracked separately
//    in AW+1 bits (full = count==DEPTH, empty = count==0).
//  - Cases, per cycle:
//      push only, not full  : mem[wr_ptr]<=rx_data, wr_ptr++, count++
//      push only, full      : byte dropped, overflow<=1, drop_cnt++ (saturate 255)
//      pop only             : rd_ptr++, count--
//      push+pop, not empty  : both occur (even when full), count unchanged, no drop
//      push+pop when empty  : pop impossible (out_valid=0); push occurs as normal
//  - out_ready with out_valid=0 is ignored; out_ready need not be held.
//  - flush=1: rd_ptr=wr_ptr=0, count=0 next cycle; any push/pop in that same cycle
//    is discarded (flush wins). overflow/drop_cnt are unaffected by flush.
//  - overflow_clr=1: overflow<=0, drop_cnt<=0, unless a drop occurs in the same
//    cycle, in which case overflow<=1 and drop_cnt<=1 (new event wins).
//  - almost_full, out_valid derive from registered count (no extra latency).
//  - No state machine beyond pointer/count registers; rx_done assumed <=1 per cycle,
//    back-to-back strobes on consecutive cycles must be accepted.
// TESTING
//  1 Reset: hold reset_n=0, toggle rx_done -> count=0, out_valid=0, overflow=0,
//    drop_cnt=0.
//  2 Single byte: rx_done with rx_data=8'hA5, out_ready=0 -> next cycle out_valid=1,
//    out_data=A5, count=1; pulse out_ready -> count=0, out_valid=0.
//  3 Fill/wrap: push 20 bytes 0x00..0x13 while popping every other cycle, then drain
//    -> output exactly 0x00..0x13 in order, pointers wrap past 15, no overflow.
//  4 Overflow: out_ready=0, push 18 bytes -> count=16, almost_full=1 from 12th push,
//    overflow=1, drop_cnt=2, out_data=first byte; overflow_clr -> overflow=0, drop_cnt=0.
//  5 Full + simultaneous push/pop: FIFO full, rx_done=1 (8'h5A) and out_ready=1 same
//    cycle -> count stays 16, no drop, 5A emerges last after draining.
//  6 Flush/reset mid-op: 5 bytes queued, flush=1 coincident with rx_done -> count=0,
//    out_valid=0 next cycle; repeat with reset_n pulsed low mid-burst -> all cleared.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Byte path between the UART receiver, the receive FIFO and its consumer.
// master = receiver/consumer side, slave = FIFO.
interface uart_rx_fifo_if;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output rx_data, rx_done, out_ready,
      input  out_data, out_valid
   );

   modport slave (
      input  rx_data, rx_done, out_ready,
      output out_data, out_valid
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures strobed UART bytes and serves them first-word-fall-through
// on valid/ready, with fill level, almost-full, sticky overflow and saturating drop count.
module uart_rx_fifo #(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int AFULL_LEVEL = 12
) (
   input  logic          clk,
   input  logic          reset_n,
   uart_rx_fifo_if.slave bus,
   input  logic          flush,
   output logic [AW:0]   count,
   output logic          almost_full,
   output logic          overflow,
   input  logic          overflow_clr,
   output logic [7:0]    drop_cnt
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LEVEL);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count_q;
   logic          full, empty;
   logic          push, pop, wr_en, drop;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   assign push = bus.rx_done;
   assign pop  = !empty && bus.out_ready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   assign bus.out_data  = mem[rd_ptr];
   assign bus.out_valid = !empty;
   assign count         = count_q;
   assign almost_full   = (count_q >= AFULL_C);

   // Storage is intentionally not reset; empty/valid gating hides stale contents.
   always_ff @(posedge clk) begin
      if (wr_en && !flush)
         mem[wr_ptr] <= bus.rx_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // A drop in the same cycle as a clear restarts the tally at one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (overflow_clr)
            drop_cnt <= 8'd1;
         else if (drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

   a_count_range : assert property (@(posedge clk) disable iff (!reset_n) count_q <= DEPTH_C);
   a_ptr_gap     : assert property (@(posedge clk) disable iff (!reset_n)
                                    (count_q < DEPTH_C) |-> (wr_ptr - rd_ptr) == count_q[AW-1:0]);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int AFULL = 12;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          flush, overflow_clr;
   logic [AW:0]   count;
   logic          almost_full, overflow;
   logic [7:0]    drop_cnt;

   uart_rx_fifo_if bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AFULL_LEVEL(AFULL)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .flush        (flush),
      .count        (count),
      .almost_full  (almost_full),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the FIFO as a plain queue plus overflow bookkeeping.
   logic [7:0] q [$];
   logic       m_ov;
   int         m_dc;
   logic [7:0] popped [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_clear_all();
      q.delete();
      m_ov = 1'b0;
      m_dc = 0;
   endtask

   task automatic m_step(input logic done, input logic [7:0] d, input logic rdy,
                         input logic fl, input logic clr);
      logic pop, drop;
      if (!reset_n) begin
         m_clear_all();
         return;
      end
      pop  = (q.size() != 0) && rdy;
      drop = done && (q.size() == DEPTH) && !pop;
      if (fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (done && !drop) q.push_back(d);
      end
      if (drop) begin
         m_ov = 1'b1;
         m_dc = clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
      end else if (clr) begin
         m_ov = 1'b0;
         m_dc = 0;
      end
   endtask

   task automatic check_all();
      chk("count", 32'(count), 32'(q.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
      if (q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(q[0]));
   endtask

   // One clock: drive, note any byte the DUT hands over, clock, update model, compare.
   task automatic cycle(input logic done, input logic [7:0] d, input logic rdy,
                        input logic fl, input logic clr);
      bus.rx_done    = done;
      bus.rx_data    = d;
      bus.out_ready  = rdy;
      flush          = fl;
      overflow_clr   = clr;
      #1;
      if (rdy && bus.out_valid && !fl && reset_n) popped.push_back(bus.out_data);
      @(posedge clk);
      m_step(done, d, rdy, fl, clr);
      #1;
      check_all();
   endtask

   initial begin
      reset_n = 1'b0;
      bus.rx_done = 1'b0; bus.rx_data = '0; bus.out_ready = 1'b0;
      flush = 1'b0; overflow_clr = 1'b0;
      m_clear_all();

      // Reset holds everything clear even with strobes arriving
      for (int i = 0; i < 4; i++) cycle(i[0] == 1'b0, 8'(8'h11 * i), 1'b1, 1'b0, 1'b0);
      chk("rst_count", 32'(count), 32'd0);
      reset_n = 1'b1;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Single byte, one-cycle latency
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      chk("single_data", 32'(bus.out_data), 32'h A5);
      chk("single_cnt", 32'(count), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("single_empty", 32'(bus.out_valid), 32'd0);

      // Fill/wrap with every-other-cycle pops, then drain
      popped.delete();
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), i[0], 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("wrap_n", 32'(popped.size()), 32'd20);
      for (int i = 0; i < 20; i++)
         if (i < popped.size()) chk("wrap_order", 32'(popped[i]), 32'(i));
      chk("wrap_ovf", 32'(overflow), 32'd0);

      // Overflow: 18 pushes into a stalled FIFO
      for (int i = 0; i < 18; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_drops", 32'(drop_cnt), 32'd2);
      chk("ovf_head", 32'(bus.out_data), 32'h30);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovf_clr", 32'(overflow), 32'd0);
      chk("ovf_clr_cnt", 32'(drop_cnt), 32'd0);

      // Full with simultaneous push+pop
      cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      chk("fullpp_count", 32'(count), 32'd16);
      chk("fullpp_drop", 32'(drop_cnt), 32'd0);
      popped.delete();
      for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("fullpp_last", 32'(popped.size() == 16 ? popped[15] : 8'h00), 32'h5A);

      // Drop counter saturation, and clear coinciding with a drop
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 262; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      chk("sat_drop", 32'(drop_cnt), 32'd255);
      cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      chk("clr_vs_drop", 32'(drop_cnt), 32'd1);
      chk("clr_vs_drop_ov", 32'(overflow), 32'd1);

      // Flush coincident with push wins; drop state untouched
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_keep_ov", 32'(overflow), 32'd1);

      // Asynchronous reset mid-burst
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
      bus.rx_done = 1'b1; bus.rx_data = 8'h83;
      @(posedge clk);
      m_step(1'b1, 8'h83, 1'b0, 1'b0, 1'b0);
      #3 reset_n = 1'b0;
      #1;
      m_clear_all();
      check_all();
      chk("async_rst", 32'(count), 32'd0);
      cycle(1'b1, 8'h84, 1'b1, 1'b0, 1'b0);
      reset_n = 1'b1;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Randomized traffic with shifting consumer speed
      begin
         int rdy_pct = 50;
         for (int n = 0; n < 4000; n++) begin
            if (n % 150 == 0) rdy_pct = $urandom_range(0, 100);
            cycle($urandom_range(0, 99) < 60, 8'($urandom),
                  $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 49) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
